add_sched: RTL and testbench
============================

# add_sched

Sequenced, shared wide adder. The block arbitrates between two requesters and runs each accepted operand pair through one internal `farc4bit` instance, one nibble per cycle, carrying between nibbles through a register. It sits between two client blocks that need occasional wide additions and the single 4-bit adder resource. It replaces per-client wide adders with one time-multiplexed 4-bit datapath.

## Interface
- `NIBBLES`, 4: number of nibbles per operand. Operand width W = 4*NIBBLES. Legal range is 1..16.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  2  request per requester; held high until granted.
- `a0`, `b0`  in  W  operands, requester 0.
- `cin0`  in  1  carry-in, requester 0.
- `a1`, `b1`  in  W  operands, requester 1.
- `cin1`  in  1  carry-in, requester 1.
- `gnt`  out  2  one-hot accept strobe; operands of the granted requester are captured at the end of this cycle.
- `busy`  out  1  high while an operation is in flight (ADD or DONE).
- `done`  out  1  one-cycle result strobe.
- `done_id`  out  1  requester index that owns the result.
- `sum`  out  W  result.
- `cout`  out  1  unsigned carry-out of the MSB nibble.
- `ovf`  out  1  signed overflow: a[W-1]==b[W-1] && sum[W-1]!=a[W-1].

## Operation
- FSM states: IDLE, ADD, DONE.
- **IDLE**
  - `gnt` is combinational: if req==2'b00, gnt=0.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester indicated by the round-robin pointer `rr`.
  - On the granting edge: capture a, b and cin of the winner; set the nibble index to 0; set the carry register to cin; latch the owner id. Go to ADD.
- **ADD**
  - Drive the adder with a[4i+3:4i], b[4i+3:4i] and the carry register.
  - Write the adder's sum into working nibble i; load the carry register from the adder cout; i++.
  - After the nibble with i==NIBBLES-1 is written, go to DONE.
- **DONE**
  - `done`=1 and `done_id`=owner.
  - `sum`, `cout` and `ovf` are output registers. They are loaded on the edge entering DONE and hold until the next DONE.
  - `rr` is set to the other requester (`rr` <= ~owner). Go to IDLE.
- Requests arriving during ADD or DONE are not granted. A requester keeps req high; req may be dropped before grant with no side effect.
- The operand inputs of the granted requester matter only in its gnt cycle.
- Arithmetic is modulo 2^W. Intermediate carry is exactly the 4-bit adder's cout; there is no lookahead.
- **Reset (rst_n low at an edge)**, from any state including mid-ADD:
  - State goes to IDLE, index to 0, `rr` to 0.
  - sum, cout, ovf, done and done_id are cleared.
  - The in-flight operation is discarded and no done is issued.

## Timing
- Reset values: gnt=0, busy=0, done=0, done_id=0, sum=0, cout=0, ovf=0.
- **Grant and ADD cycles:** gnt is in cycle T, the same cycle req is seen in IDLE. ADD occupies cycles T+1 .. T+NIBBLES.
- **DONE cycle:** DONE occupies T+NIBBLES+1. With NIBBLES=4, done is 5 cycles after gnt.
- **busy:** high during T+1 .. T+NIBBLES+1.
- **Throughput:** the earliest next gnt is T+NIBBLES+2, giving one operation per NIBBLES+2 cycles.
- **Continuous contention:** under continuous dual requests, grants strictly alternate.
- **NIBBLES=1:** a single ADD cycle, then DONE.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with req=2'b11. Required: all outputs 0, no gnt, busy=0.
- **Single request:** req=2'b01, a0=0x1234, b0=0x0FCD, cin0=0. Required: gnt=01, then done 5 cycles later with sum=0x2201, cout=0, ovf=0, done_id=0.
- **Full carry ripple:** req1, a1=0xFFFF, b1=0x0001, cin1=0. Required: sum=0x0000, cout=1, ovf=0, done_id=1. Also a=0, b=0, cin=1 gives sum=0x0001.
- **Simultaneous requests, held:** req=2'b11 from reset, with a1=0x7FFF, b1=0x0001. Required: gnt order 01 then 10 (second gnt 6 cycles after first). done_id sequence 0, then 1. The second result is sum=0x8000, ovf=1, cout=0.
- **Reset mid-operation:** rst_n=0 in the 2nd ADD cycle. Required: IDLE next cycle, busy=0, no done ever emitted for that operation. A following req=2'b11 grants requester 0.
- **Request withdrawn and late arrival:** req0 pulsed during busy, then dropped. Required: no grant to requester 0, and the sum of the current operation is unaffected.

Source files
------------

// File: rtl/add_sched.sv
// add_sched: sequenced, shared wide adder.
//
// Two requesters compete for one 4-bit ripple adder (farc4bit). An accepted
// operand pair is added one nibble per cycle, least-significant nibble first,
// with the inter-nibble carry held in a register.
//
// Ports:
//   clk      - clock, all state changes on rising edge
//   rst_n    - synchronous active-low reset
//   req      - per-requester request, held high until granted
//   a0,b0    - requester 0 operands (W = 4*NIBBLES bits)
//   cin0     - requester 0 carry-in
//   a1,b1    - requester 1 operands
//   cin1     - requester 1 carry-in
//   gnt      - one-hot accept strobe (combinational, IDLE only)
//   busy     - operation in flight (ADD or DONE)
//   done     - one-cycle result strobe
//   done_id  - requester that owns the result
//   sum      - registered result, held until the next DONE
//   cout     - unsigned carry-out of the MSB nibble
//   ovf      - signed overflow of the result

module farc4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[4];
  end

endmodule

module add_sched #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic                   cin0,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  input  logic                   cin1,
  output logic [1:0]             gnt,
  output logic                   busy,
  output logic                   done,
  output logic                   done_id,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    work;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            owner;
  logic            rr;

  logic [3:0]      nib_sum;
  logic            nib_co;
  logic [W-1:0]    next_work;
  logic            last;

  // Operands are shifted right each ADD cycle, so the active nibble is always
  // the low nibble; the working result shifts in from the top. After NIBBLES
  // steps the working register holds the result in natural order, and during
  // the last step a_r[3]/b_r[3] are the operand sign bits.
  farc4bit u_add (
    .a    (a_r[3:0]),
    .b    (b_r[3:0]),
    .cin  (carry),
    .s    (nib_sum),
    .cout (nib_co)
  );

  always_comb begin
    next_work = (work >> 4) | (W'(nib_sum) << (W - 4));
    last      = (idx == IW'(NIBBLES - 1));
  end

  // Grant is suppressed while reset is asserted so a held request cannot be
  // seen as accepted during reset.
  always_comb begin
    gnt = '0;
    if (rst_n && state == IDLE) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      work    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      owner   <= 1'b0;
      rr      <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (gnt != 2'b00) begin
            a_r   <= gnt[1] ? a1 : a0;
            b_r   <= gnt[1] ? b1 : b0;
            carry <= gnt[1] ? cin1 : cin0;
            owner <= gnt[1];
            idx   <= '0;
            work  <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          work  <= next_work;
          carry <= nib_co;
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          idx   <= idx + IW'(1);
          if (last) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= owner;
            sum     <= next_work;
            cout    <= nib_co;
            ovf     <= (a_r[3] == b_r[3]) && (nib_sum[3] != a_r[3]);
          end
        end
        DONE: begin
          done  <= 1'b0;
          rr    <= ~owner;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sched.sv
// Directed testbench for add_sched (NIBBLES = 4, W = 16).
module tb_add_sched;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           cin0, cin1;
  logic [1:0]     gnt;
  logic           busy, done, done_id, cout, ovf;
  logic [W-1:0]   sum;

  int n_assert = 0;
  int n_fail   = 0;

  add_sched #(.NIBBLES(NIB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .cin0    (cin0),
    .a1      (a1),
    .b1      (b1),
    .cin1    (cin1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the grant cycle T (after gnt was checked); walks through the
  // ADD cycles and DONE, and returns in cycle T+NIB+2 (back in IDLE).
  task automatic finish_op(input string tag, input logic id, input logic [W-1:0] s,
                           input logic co, input logic ov);
    for (int i = 1; i <= int'(NIB); i++) begin
      tick();
      chk({tag, "_add_busy"}, 32'(busy), 32'd1);
      chk({tag, "_add_done"}, 32'(done), 32'd0);
      chk({tag, "_add_gnt"},  32'(gnt),  32'd0);
    end
    tick();
    chk({tag, "_done"},    32'(done),    32'd1);
    chk({tag, "_busy"},    32'(busy),    32'd1);
    chk({tag, "_done_id"}, 32'(done_id), 32'(id));
    chk({tag, "_sum"},     32'(sum),     32'(s));
    chk({tag, "_cout"},    32'(cout),    32'(co));
    chk({tag, "_ovf"},     32'(ovf),     32'(ov));
    tick();
    chk({tag, "_post_done"}, 32'(done), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
    chk({tag, "_post_sum"},  32'(sum),  32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    a0 = 16'h1234; b0 = 16'h0FCD; cin0 = 1'b0;
    a1 = 16'h7FFF; b1 = 16'h0001; cin1 = 1'b0;

    // Reset held two cycles with both requests high.
    tick();
    chk("rst_gnt_c1",  32'(gnt),  32'd0);
    chk("rst_busy_c1", 32'(busy), 32'd0);
    tick();
    chk("rst_gnt",     32'(gnt),     32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_sum",     32'(sum),     32'd0);
    chk("rst_cout",    32'(cout),    32'd0);
    chk("rst_ovf",     32'(ovf),     32'd0);

    // Simultaneous held requests: 0 first, then 1 six cycles later.
    rst_n = 1'b1;
    #1;
    chk("dual_gnt0", 32'(gnt), 32'h1);
    finish_op("dual_op0", 1'b0, 16'h2201, 1'b0, 1'b0);
    chk("dual_gnt1", 32'(gnt), 32'h2);
    finish_op("dual_op1", 1'b1, 16'h8000, 1'b0, 1'b1);
    chk("dual_gnt2", 32'(gnt), 32'h1);
    req = 2'b00;
    #1;
    chk("drop_gnt", 32'(gnt), 32'd0);
    tick();
    chk("drop_busy", 32'(busy), 32'd0);

    // Full carry ripple through every nibble, requester 1 alone.
    req = 2'b10; a1 = 16'hFFFF; b1 = 16'h0001; cin1 = 1'b0;
    #1;
    chk("ripple_gnt", 32'(gnt), 32'h2);
    finish_op("ripple", 1'b1, 16'h0000, 1'b1, 1'b0);

    // Late arrival: req0 pulsed during busy, then dropped.
    req = 2'b10; a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b1;
    #1;
    chk("late_gnt", 32'(gnt), 32'h2);
    tick();
    req = 2'b01; a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 1'b1;
    a1 = 16'h0000; b1 = 16'h0000; cin1 = 1'b0;
    #1;
    chk("late_pulse_gnt", 32'(gnt), 32'd0);
    tick();
    req = 2'b00;
    chk("late_pulse_busy", 32'(busy), 32'd1);
    for (int i = 3; i <= int'(NIB); i++) begin
      tick();
      chk("late_add_done", 32'(done), 32'd0);
    end
    tick();
    chk("late_done",    32'(done),    32'd1);
    chk("late_done_id", 32'(done_id), 32'd1);
    chk("late_sum",     32'(sum),     32'h0001);
    chk("late_cout",    32'(cout),    32'd1);
    chk("late_ovf",     32'(ovf),     32'd1);
    tick();
    chk("late_idle_gnt",  32'(gnt),  32'd0);
    tick();
    chk("late_idle_busy", 32'(busy), 32'd0);

    // Carry-in only, requester 0; leaves rr pointing at requester 1.
    req = 2'b01; a0 = 16'h0000; b0 = 16'h0000; cin0 = 1'b1;
    #1;
    chk("cin_gnt", 32'(gnt), 32'h1);
    finish_op("cin", 1'b0, 16'h0001, 1'b0, 1'b0);
    req = 2'b00;

    // Reset in the 2nd ADD cycle of a requester-1 operation.
    req = 2'b10; a1 = 16'h1111; b1 = 16'h1111; cin1 = 1'b0;
    #1;
    chk("mid_gnt", 32'(gnt), 32'h2);
    tick();
    req = 2'b00;
    tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy",    32'(busy),    32'd0);
    chk("mid_done",    32'(done),    32'd0);
    chk("mid_sum",     32'(sum),     32'd0);
    chk("mid_done_id", 32'(done_id), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_done", 32'(done), 32'd0);
    end

    // rr was cleared by reset, so a dual request grants requester 0.
    req = 2'b11; a0 = 16'h0F0F; b0 = 16'h0101; cin0 = 1'b0;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    req = 2'b01;
    finish_op("post_rst", 1'b0, 16'h1010, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
